riio_bias_seq_ctrl: RTL

Digital power-up sequencer for the IO-domain bandgap/bias macro. It runs in the core VDD domain and drives the macro's enable, startup and trim inputs. It qualifies the macro's asynchronous bandgap-valid flag, enforces startup and settle windows, and gates a parametrised number of current-bias channels until the bias is trusted. It also adds trim reload and fault detection, which the bare macro does not have.

---
 rtl/riio_bias_seq_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/riio_bias_seq_ctrl.sv
// rtl/riio_bias_seq_ctrl.sv - power-up sequencer for the IO-domain bandgap/bias macro
//
// Purpose: drives the bias macro enable, startup kick and trims. It qualifies
// the asynchronous bandgap-valid flag, times the startup and settle windows,
// gates the IBIAS channels until the bias is trusted, reloads trims on request
// and flags a fault when the bandgap is not (or no longer) valid.
//
// Ports:
//   CLK_I, RSTN_I             clock, asynchronous active-low reset
//   EN_REQ_I, VBIAS_REQ_I     enable request, VBIAS request (sampled at start)
//   CH_MASK_I                 per-channel enable request
//   TRIM_I_I, TRIM_V_I        trim values, TRIM_LOAD_I reload strobe (READY only)
//   BG_VALID_I                asynchronous macro valid flag
//   EN_IBIAS_O, EN_VBIAS_O    macro bias enables
//   BG_STARTUP_O              macro startup kick
//   TRIM_I_O, TRIM_V_O        registered trims to the macro
//   CH_EN_O, READY_O          gated channel enables, bias ready
//   FAULT_O                   sticky fault, cleared by dropping EN_REQ_I
module riio_bias_seq_ctrl #(
  parameter int NUM_CH      = 16,
  parameter int TRIM_I_W    = 5,
  parameter int TRIM_V_W    = 4,
  parameter int STARTUP_CYC = 16,
  parameter int SETTLE_CYC  = 64
) (
  input  logic                CLK_I,
  input  logic                RSTN_I,
  input  logic                EN_REQ_I,
  input  logic                VBIAS_REQ_I,
  input  logic [NUM_CH-1:0]   CH_MASK_I,
  input  logic [TRIM_I_W-1:0] TRIM_I_I,
  input  logic [TRIM_V_W-1:0] TRIM_V_I,
  input  logic                TRIM_LOAD_I,
  input  logic                BG_VALID_I,
  output logic                EN_IBIAS_O,
  output logic                EN_VBIAS_O,
  output logic                BG_STARTUP_O,
  output logic [TRIM_I_W-1:0] TRIM_I_O,
  output logic [TRIM_V_W-1:0] TRIM_V_O,
  output logic [NUM_CH-1:0]   CH_EN_O,
  output logic                READY_O,
  output logic                FAULT_O
);

  localparam int MAX_CYC = (STARTUP_CYC > SETTLE_CYC) ? STARTUP_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] C_STARTUP = CNT_W'(STARTUP_CYC);
  localparam logic [CNT_W-1:0] C_SETTLE  = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_OFF,
    S_STARTUP,
    S_SETTLE,
    S_READY,
    S_FAULT
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_bg_meta;
  logic                r_bg_sync;
  logic                r_en_ibias;
  logic                r_en_vbias;
  logic                r_startup;
  logic [TRIM_I_W-1:0] r_trim_i;
  logic [TRIM_V_W-1:0] r_trim_v;
  logic [NUM_CH-1:0]   r_ch_en;
  logic                r_ready;
  logic                r_fault;

  // Two-flop synchroniser for the macro's asynchronous valid flag.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_bg_meta <= 1'b0;
      r_bg_sync <= 1'b0;
    end else begin
      r_bg_meta <= BG_VALID_I;
      r_bg_sync <= r_bg_meta;
    end
  end

  // One counter serves both the startup and the settle window.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_state    <= S_OFF;
      r_cnt      <= '0;
      r_en_ibias <= 1'b0;
      r_en_vbias <= 1'b0;
      r_startup  <= 1'b0;
      r_trim_i   <= '0;
      r_trim_v   <= '0;
      r_ch_en    <= '0;
      r_ready    <= 1'b0;
      r_fault    <= 1'b0;
    end else if (!EN_REQ_I) begin
      // Dropping the request wins over everything; trims keep their value.
      r_state    <= S_OFF;
      r_cnt      <= '0;
      r_en_ibias <= 1'b0;
      r_en_vbias <= 1'b0;
      r_startup  <= 1'b0;
      r_ch_en    <= '0;
      r_ready    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          r_trim_i   <= TRIM_I_I;
          r_trim_v   <= TRIM_V_I;
          r_en_vbias <= VBIAS_REQ_I;
          r_en_ibias <= 1'b1;
          r_startup  <= 1'b1;
          r_cnt      <= C_STARTUP;
          r_state    <= S_STARTUP;
        end
        S_STARTUP: begin
          if (r_cnt == C_ONE) begin
            r_startup <= 1'b0;
            r_cnt     <= C_SETTLE;
            r_state   <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == C_ONE) begin
            r_cnt <= '0;
            if (r_bg_sync) begin
              r_ready <= 1'b1;
              r_state <= S_READY;
            end else begin
              r_fault    <= 1'b1;
              r_en_ibias <= 1'b0;
              r_en_vbias <= 1'b0;
              r_state    <= S_FAULT;
            end
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_READY: begin
          if (TRIM_LOAD_I) begin
            // Trim reload re-enters the settle window without a startup kick.
            r_trim_i <= TRIM_I_I;
            r_trim_v <= TRIM_V_I;
            r_ready  <= 1'b0;
            r_ch_en  <= '0;
            r_cnt    <= C_SETTLE;
            r_state  <= S_SETTLE;
          end else if (!r_bg_sync) begin
            r_ready    <= 1'b0;
            r_ch_en    <= '0;
            r_fault    <= 1'b1;
            r_en_ibias <= 1'b0;
            r_en_vbias <= 1'b0;
            r_state    <= S_FAULT;
          end else begin
            r_ch_en <= CH_MASK_I;
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_OFF;
        end
      endcase
    end
  end

  assign EN_IBIAS_O   = r_en_ibias;
  assign EN_VBIAS_O   = r_en_vbias;
  assign BG_STARTUP_O = r_startup;
  assign TRIM_I_O     = r_trim_i;
  assign TRIM_V_O     = r_trim_v;
  assign CH_EN_O      = r_ch_en;
  assign READY_O      = r_ready;
  assign FAULT_O      = r_fault;

endmodule
